// File: rtl/mc8051_boot_seq_if.sv
// Host download channel into the boot sequencer.
// The host drives the strobes, address and data. The sequencer answers with dl_ack.
interface mc8051_boot_seq_if;
    logic        dl_start;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_done;
    logic        dl_ack;

    modport master (output dl_start, dl_wr, dl_addr, dl_data, dl_done, input dl_ack);
    modport slave  (input dl_start, dl_wr, dl_addr, dl_data, dl_done, output dl_ack);
endinterface

// File: rtl/mc8051_boot_seq.sv
// Boot and reset sequencer for the 8051 core.
// The core is held in reset while the host downloads program bytes into ROM.
// The internal RAM is then zero-filled, and the core is released after a hold time.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | one cycle after reset, then clear RAM
// LOAD  | host download in progress, bytes forwarded to program ROM
// CLEAR | write CLEAR_VAL to every internal RAM location, one per cycle
// HOLD  | keep the core in reset for RST_HOLD cycles
// RUN   | core released, RAM port passes through from the core
module mc8051_boot_seq #(
    parameter int          ROM_AW    = 13,
    parameter int          RAM_AW    = 7,
    parameter int          RST_HOLD  = 16,
    parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    mc8051_boot_seq_if.slave  dl,
    input  logic [RAM_AW-1:0] core_ram_adr_i,
    input  logic [7:0]        core_ram_data_i,
    input  logic              core_ram_wr_i,
    input  logic              core_ram_en_i,
    output logic [RAM_AW-1:0] ram_adr_o,
    output logic [7:0]        ram_data_o,
    output logic              ram_wr_o,
    output logic              ram_en_o,
    output logic              rom_wr_o,
    output logic [ROM_AW-1:0] rom_wadr_o,
    output logic [7:0]        rom_wdata_o,
    output logic              core_reset_o,
    output logic              ready_o,
    output logic              ovf_o
);

    localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
    localparam logic [RAM_AW-1:0] CLR_LAST  = {RAM_AW{1'b1}};

    typedef enum logic [2:0] {INIT, LOAD, CLEAR, HOLD, RUN} state_t;

    state_t            state, next_state;
    logic [RAM_AW-1:0] clr_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              in_rom;
    logic              load_wr;

    assign in_rom  = ({16'd0, dl.dl_addr} < (32'd1 << ROM_AW));
    assign load_wr = dl.dl_wr && (state == LOAD);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= INIT;
        else          state <= next_state;
    end

    // Next-state logic; dl_start overrides every other transition
    always_comb begin
        next_state = state;
        case (state)
            INIT:    next_state = CLEAR;
            LOAD:    if (dl.dl_done) next_state = CLEAR;
            CLEAR:   if (clr_cnt == CLR_LAST) next_state = HOLD;
            HOLD:    if (hold_cnt == '0) next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = INIT;
        endcase
        if (dl.dl_start) next_state = LOAD;
    end

    // Clear address counter: wraps back to 0 at the end of CLEAR and restarts on a new download
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            clr_cnt <= '0;
        else if (dl.dl_start)    clr_cnt <= '0;
        else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end

    // Hold down-counter: loaded when leaving CLEAR, HOLD ends when it reaches 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hold_cnt <= '0;
        else if (state == CLEAR && next_state == HOLD)
            hold_cnt <= HOLD_LOAD;
        else if (state == HOLD && hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;
    end

    // RAM port: the clear engine owns it in CLEAR, the core owns it in RUN
    always_comb begin
        ram_adr_o  = '0;
        ram_data_o = '0;
        ram_wr_o   = 1'b0;
        ram_en_o   = 1'b0;
        if (state == CLEAR) begin
            ram_adr_o  = clr_cnt;
            ram_data_o = CLEAR_VAL;
            ram_wr_o   = 1'b1;
            ram_en_o   = 1'b1;
        end else if (state == RUN) begin
            ram_adr_o  = core_ram_adr_i;
            ram_data_o = core_ram_data_i;
            ram_wr_o   = core_ram_wr_i;
            ram_en_o   = core_ram_en_i;
        end
    end

    // Core reset and ready, registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_reset_o <= 1'b1;
            ready_o      <= 1'b0;
        end else begin
            core_reset_o <= (next_state != RUN);
            ready_o      <= (next_state == RUN);
        end
    end

    // ROM write port and ack. Address and data hold between writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_wr_o    <= 1'b0;
            rom_wadr_o  <= '0;
            rom_wdata_o <= '0;
            dl.dl_ack   <= 1'b0;
        end else begin
            rom_wr_o  <= load_wr && in_rom;
            dl.dl_ack <= load_wr;
            if (load_wr && in_rom) begin
                rom_wadr_o  <= dl.dl_addr[ROM_AW-1:0];
                rom_wdata_o <= dl.dl_data;
            end
        end
    end

    // Sticky overflow flag: cleared by a new download, set by an out-of-range byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 ovf_o <= 1'b0;
        else if (dl.dl_start)         ovf_o <= 1'b0;
        else if (load_wr && !in_rom)  ovf_o <= 1'b1;
    end

endmodule

// File: tb/tb_mc8051_boot_seq.sv
// Bench for mc8051_boot_seq.
// Expected ROM writes, acks and RAM clear addresses are queued as stimulus is issued.
// A monitor process pops the queues and compares whenever the DUT presents an output.
module tb_mc8051_boot_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] core_ram_adr_i = '0;
    logic [7:0] core_ram_data_i = '0;
    logic       core_ram_wr_i = 1'b0;
    logic       core_ram_en_i = 1'b0;
    logic [6:0] ram_adr_o;
    logic [7:0] ram_data_o;
    logic       ram_wr_o, ram_en_o, rom_wr_o;
    logic [12:0] rom_wadr_o;
    logic [7:0] rom_wdata_o;
    logic       core_reset_o, ready_o, ovf_o;

    mc8051_boot_seq_if dl_bus ();

    mc8051_boot_seq dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .dl              (dl_bus),
        .core_ram_adr_i  (core_ram_adr_i),
        .core_ram_data_i (core_ram_data_i),
        .core_ram_wr_i   (core_ram_wr_i),
        .core_ram_en_i   (core_ram_en_i),
        .ram_adr_o       (ram_adr_o),
        .ram_data_o      (ram_data_o),
        .ram_wr_o        (ram_wr_o),
        .ram_en_o        (ram_en_o),
        .rom_wr_o        (rom_wr_o),
        .rom_wadr_o      (rom_wadr_o),
        .rom_wdata_o     (rom_wdata_o),
        .core_reset_o    (core_reset_o),
        .ready_o         (ready_o),
        .ovf_o           (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] a;
        logic [7:0]  d;
    } rom_t;

    rom_t       rom_q[$];
    logic [6:0] clr_q[$];
    int         ack_pend = 0;
    int         rom_seen = 0;
    int         ack_seen = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_clear();
        for (int i = 0; i < 128; i++) clr_q.push_back(7'(i));
    endtask

    task automatic chk_reset_vals();
        chk("rst_core_reset", core_reset_o, 1);
        chk("rst_ready", ready_o, 0);
        chk("rst_rom_wr", rom_wr_o, 0);
        chk("rst_rom_wadr", rom_wadr_o, 0);
        chk("rst_rom_wdata", rom_wdata_o, 0);
        chk("rst_dl_ack", dl_bus.dl_ack, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_ram_en", ram_en_o, 0);
        chk("rst_ram_wr", ram_wr_o, 0);
    endtask

    // Count rising edges after the current point until core_reset_o falls
    task automatic edges_to_release(output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #2;
            if (!core_reset_o) begin
                n = i;
                break;
            end
        end
    endtask

    // Monitor: pops expectations whenever the DUT emits a ROM write, an ack or a clear write
    always @(posedge clk) begin
        #2;
        if (rom_wr_o) begin
            rom_seen++;
            if (rom_q.size() == 0) begin
                chk("rom_unexpected", 1, 0);
            end else begin
                rom_t e;
                e = rom_q.pop_front();
                chk("rom_wadr", rom_wadr_o, e.a);
                chk("rom_wdata", rom_wdata_o, e.d);
            end
        end
        if (dl_bus.dl_ack) begin
            ack_seen++;
            if (ack_pend == 0) chk("ack_unexpected", 1, 0);
            else ack_pend--;
        end
        if (ram_wr_o && core_reset_o) begin
            if (clr_q.size() == 0) begin
                chk("clear_unexpected", 1, 0);
            end else begin
                logic [6:0] ea;
                ea = clr_q.pop_front();
                chk("clear_adr", ram_adr_o, ea);
                chk("clear_data", ram_data_o, 8'h00);
                chk("clear_en", ram_en_o, 1);
            end
        end
    end

    int n;

    initial begin
        dl_bus.dl_start = 0;
        dl_bus.dl_wr    = 0;
        dl_bus.dl_addr  = '0;
        dl_bus.dl_data  = '0;
        dl_bus.dl_done  = 0;

        // Power-up
        repeat (3) @(negedge clk);
        chk_reset_vals();
        push_clear();
        reset_n = 1;
        edges_to_release(n);
        chk("powerup_release_edge", n, 145);
        chk("powerup_clear_done", clr_q.size(), 0);
        chk("powerup_ready", ready_o, 1);
        core_ram_adr_i = 7'h55; core_ram_data_i = 8'h3C;
        core_ram_wr_i = 1; core_ram_en_i = 1;
        #1;
        chk("pass_adr", ram_adr_o, 7'h55);
        chk("pass_data", ram_data_o, 8'h3C);
        chk("pass_wr", ram_wr_o, 1);
        chk("pass_en", ram_en_o, 1);
        core_ram_adr_i = '0; core_ram_data_i = '0;
        core_ram_wr_i = 0; core_ram_en_i = 0;

        // Download while running: three back-to-back bytes
        @(negedge clk) dl_bus.dl_start = 1;
        @(negedge clk) dl_bus.dl_start = 0;
        chk("dl_core_reset", core_reset_o, 1);
        chk("dl_ready", ready_o, 0);
        rom_q.push_back('{13'h0000, 8'h02});
        rom_q.push_back('{13'h0001, 8'h10});
        rom_q.push_back('{13'h1FFF, 8'hA5});
        ack_pend += 3;
        dl_bus.dl_wr = 1; dl_bus.dl_addr = 16'h0000; dl_bus.dl_data = 8'h02;
        @(negedge clk) begin dl_bus.dl_addr = 16'h0001; dl_bus.dl_data = 8'h10; end
        @(negedge clk) begin dl_bus.dl_addr = 16'h1FFF; dl_bus.dl_data = 8'hA5; end
        @(negedge clk) dl_bus.dl_wr = 0;
        repeat (2) @(negedge clk);
        chk("dl_rom_all", rom_q.size(), 0);
        chk("dl_ack_all", ack_pend, 0);
        chk("dl_ovf", ovf_o, 0);

        // Overflow byte
        ack_pend += 1;
        dl_bus.dl_wr = 1; dl_bus.dl_addr = 16'h2000; dl_bus.dl_data = 8'hEE;
        @(negedge clk) dl_bus.dl_wr = 0;
        repeat (2) @(negedge clk);
        chk("ovf_set", ovf_o, 1);
        chk("ovf_ack", ack_pend, 0);
        chk("ovf_wadr_hold", rom_wadr_o, 13'h1FFF);
        chk("ovf_wdata_hold", rom_wdata_o, 8'hA5);
        dl_bus.dl_start = 1;
        @(negedge clk) dl_bus.dl_start = 0;
        chk("ovf_cleared", ovf_o, 0);

        // dl_done with simultaneous write, then CLEAR and HOLD
        rom_q.push_back('{13'h0100, 8'h77});
        ack_pend += 1;
        push_clear();
        dl_bus.dl_done = 1; dl_bus.dl_wr = 1;
        dl_bus.dl_addr = 16'h0100; dl_bus.dl_data = 8'h77;
        @(posedge clk); #2;
        dl_bus.dl_done = 0; dl_bus.dl_wr = 0;
        edges_to_release(n);
        chk("done_release_edge", n, 144);
        chk("done_clear_all", clr_q.size(), 0);
        chk("done_rom_all", rom_q.size(), 0);

        // Stray strobes in RUN
        @(negedge clk) begin
            dl_bus.dl_wr = 1; dl_bus.dl_done = 1;
            dl_bus.dl_addr = 16'h0010; dl_bus.dl_data = 8'h55;
        end
        @(negedge clk) begin dl_bus.dl_wr = 0; dl_bus.dl_done = 0; end
        repeat (3) @(negedge clk);
        chk("stray_core_reset", core_reset_o, 0);
        chk("stray_ready", ready_o, 1);

        // Reset in the middle of CLEAR at address 40
        @(negedge clk) dl_bus.dl_start = 1;
        @(negedge clk) begin dl_bus.dl_start = 0; dl_bus.dl_done = 1; end
        push_clear();
        @(negedge clk) dl_bus.dl_done = 0;
        n = -1;
        for (int i = 0; i < 300; i++) begin
            if (ram_wr_o && ram_adr_o == 7'd40) begin
                n = i;
                break;
            end
            @(negedge clk);
        end
        chk("midclear_reached", (n >= 0), 1);
        reset_n = 0;
        #1;
        chk_reset_vals();
        clr_q.delete();
        push_clear();
        repeat (3) @(negedge clk);
        chk("midclear_held_wr", ram_wr_o, 0);
        reset_n = 1;
        edges_to_release(n);
        chk("midclear_release_edge", n, 145);
        chk("midclear_clear_all", clr_q.size(), 0);

        repeat (2) @(negedge clk);
        chk("total_rom_writes", rom_seen, 4);
        chk("total_acks", ack_seen, 5);
        chk("final_ack_pend", ack_pend, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc8051_boot_seq.md
Name: mc8051_boot_seq

Overview:
Boot and reset sequencer for the 8051 core.
- Holds the core in reset while a host download streams program bytes into program ROM.
- Zero-fills the 128-byte internal RAM, then releases the core.
- Sits between the core's internal-RAM port and the RAM block, and drives the core reset and the ROM write port.

Parameters:
ROM_AW, 13, program ROM address width (8 KB).
RAM_AW, 7, internal RAM address width (128 bytes).
RST_HOLD, 16, cycles core reset stays asserted after RAM clear (>=1).
CLEAR_VAL, 8'h00, byte written to every internal RAM location.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
dl_start  in  1  one-cycle pulse: begin download.
dl_wr  in  1  download byte strobe.
dl_addr  in  16  download byte address.
dl_data  in  8  download byte.
dl_done  in  1  one-cycle pulse: download finished.
dl_ack  out  1  byte accepted (one cycle after dl_wr).
core_ram_adr_i  in  RAM_AW  core internal-RAM address.
core_ram_data_i  in  8  core internal-RAM write data.
core_ram_wr_i  in  1  core internal-RAM write.
core_ram_en_i  in  1  core internal-RAM enable.
ram_adr_o  out  RAM_AW  internal RAM address.
ram_data_o  out  8  internal RAM write data.
ram_wr_o  out  1  internal RAM write.
ram_en_o  out  1  internal RAM enable.
rom_wr_o  out  1  program ROM write strobe.
rom_wadr_o  out  ROM_AW  program ROM write address.
rom_wdata_o  out  8  program ROM write data.
core_reset_o  out  1  active-high reset to the core.
ready_o  out  1  core running.
ovf_o  out  1  sticky: a download byte fell outside the ROM.

Behaviour:
- Reset values (reset_n low): state INIT, clear counter 0, hold counter 0, core_reset_o=1, ready_o=0, rom_wr_o=0, rom_wadr_o=0, rom_wdata_o=0, dl_ack=0, ovf_o=0, ram_en_o=0, ram_wr_o=0.
- Reset asserted mid-operation aborts everything immediately; no partial write is emitted.
- States: INIT, LOAD, CLEAR, HOLD, RUN.
- INIT: lasts 1 cycle, then CLEAR. Taken only after reset.
- CLEAR:
  - Counter runs 0 .. 2^RAM_AW-1, one location per cycle.
  - ram_en_o=1, ram_wr_o=1, ram_adr_o=counter, ram_data_o=CLEAR_VAL.
  - Lasts exactly 2^RAM_AW cycles, then HOLD.
- HOLD: RST_HOLD cycles, ram_en_o=ram_wr_o=0, then RUN.
- RUN:
  - ram_* outputs are combinational pass-through of core_ram_*_i.
  - ready_o=1.
- core_reset_o and ready_o are registered.
  - core_reset_o=1 in every state except RUN.
  - After reset_n deasserts, core_reset_o falls at rising edge 1+2^RAM_AW+RST_HOLD (145 with defaults).
- dl_start in any state:
  - Next state LOAD; ovf_o cleared; core_reset_o=1 and ready_o=0 from the next edge.
  - The clear counter reloads to 0 for the following CLEAR.
  - dl_start while already in LOAD restarts LOAD.
- LOAD:
  - dl_wr sampled in cycle N. If dl_addr < 2^ROM_AW: rom_wr_o=1, rom_wadr_o=dl_addr[ROM_AW-1:0], rom_wdata_o=dl_data in cycle N+1.
  - dl_ack=1 in N+1 for every dl_wr, including rejected ones.
  - Out-of-range address: rom_wr_o stays 0, ovf_o set.
  - dl_wr on consecutive cycles is fully supported: throughput 1 byte/cycle.
  - ram_en_o=ram_wr_o=0.
- dl_done in LOAD: next state CLEAR. A dl_wr in the same cycle is still written in N+1.
- dl_done outside LOAD: ignored.
- dl_wr outside LOAD: ignored; no dl_ack, no rom_wr_o.
- dl_start and dl_done in the same cycle: dl_start wins.
- rom_wr_o and dl_ack are single-cycle pulses.
- rom_wadr_o and rom_wdata_o hold their last value when rom_wr_o=0.

Test Plan:
- Power-up: release reset_n, no downloads -> ram_wr_o high for 128 cycles at addresses 0..127 with data 00; core_reset_o low at edge 145; ready_o=1; core_ram_adr_i=7'h55 appears on ram_adr_o.
- Download while running: dl_start, then dl_wr at 0x0000=0x02, 0x0001=0x10, 0x1FFF=0xA5 back-to-back -> core_reset_o=1 the cycle after dl_start; rom_wr_o pulses on 3 consecutive cycles with matching address/data; 3 dl_ack pulses; ovf_o=0.
- Overflow: in LOAD, dl_wr at 0x2000 -> dl_ack=1, rom_wr_o=0, ovf_o=1; next dl_start clears ovf_o.
- dl_done with a simultaneous dl_wr at 0x0100=0x77 -> ROM write occurs; CLEAR runs 128 cycles; core_reset_o falls 128+16 cycles after the CLEAR entry edge.
- Stray strobes: dl_wr and dl_done during RUN -> no rom_wr_o, no dl_ack, core_reset_o stays 0.
- Reset mid-CLEAR at counter 40 -> all outputs at reset values while reset_n low; after release, CLEAR restarts at address 0.
